// File: rtl/matrix_key_scanner.sv
`default_nettype none
// ============================================================================
// Module  : matrix_key_scanner
// Brief   : Row-scanned push-button matrix reader. Drives one row low per scan
//           tick, debounces a single key and reports it over a valid/ack
//           handshake. Optional macro KEY_RELEASE_EVENT_EN adds release events.
// Revision: 1.0 - initial release
// ============================================================================
module matrix_key_scanner #(
  parameter int ROWS             = 4,
  parameter int COLS             = 4,
  parameter int SCAN_DIV         = 16384,
  parameter int DEBOUNCE_SAMPLES = 4,
  localparam int CODE_W = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ROWS-1:0]   rowDrive,
  input  logic [COLS-1:0]   colSense,
  output logic              keyValid,
  output logic [CODE_W-1:0] keyCode,
  input  logic              keyAck,
  output logic              keyOverflow
`ifdef KEY_RELEASE_EVENT_EN
  ,
  output logic              keyRelease
`endif
);

  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CNT_W = $clog2(DEBOUNCE_SAMPLES + 1);
  localparam bit ONE_SAMPLE = (DEBOUNCE_SAMPLES == 1);

  localparam logic [1:0] ST_SCAN    = 2'd0;
  localparam logic [1:0] ST_CONFIRM = 2'd1;
  localparam logic [1:0] ST_HELD    = 2'd2;

  logic [COLS-1:0]   sync1_q, sync1_d;
  logic [COLS-1:0]   csync_q, csync_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [1:0]        state_q, state_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [ROW_W-1:0]  cand_row_q, cand_row_d;
  logic [COL_W-1:0]  cand_col_q, cand_col_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  rel_cnt_q, rel_cnt_d;
  logic              key_valid_q, key_valid_d;
  logic [CODE_W-1:0] key_code_q, key_code_d;
  logic              key_ovf_q, key_ovf_d;
`ifdef KEY_RELEASE_EVENT_EN
  logic              key_rel_q, key_rel_d;
`endif

  logic              tick;
  logic              hit;
  logic [COL_W-1:0]  col;
  logic              cand_low;
  logic [ROW_W-1:0]  row_next;
  logic              press_evt;
  logic              rel_evt;
  logic              evt;
  logic [CODE_W-1:0] evt_code;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q     <= '1;
      csync_q     <= '1;
      div_q       <= '0;
      state_q     <= ST_SCAN;
      row_q       <= '0;
      cand_row_q  <= '0;
      cand_col_q  <= '0;
      cnt_q       <= '0;
      rel_cnt_q   <= '0;
      key_valid_q <= 1'b0;
      key_code_q  <= '0;
      key_ovf_q   <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      csync_q     <= csync_d;
      div_q       <= div_d;
      state_q     <= state_d;
      row_q       <= row_d;
      cand_row_q  <= cand_row_d;
      cand_col_q  <= cand_col_d;
      cnt_q       <= cnt_d;
      rel_cnt_q   <= rel_cnt_d;
      key_valid_q <= key_valid_d;
      key_code_q  <= key_code_d;
      key_ovf_q   <= key_ovf_d;
    end
  end

`ifdef KEY_RELEASE_EVENT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      key_rel_q <= 1'b0;
    end else begin
      key_rel_q <= key_rel_d;
    end
  end
`endif

  // Lowest-index low column wins when several keys share the scanned row
  always_comb begin
    hit = 1'b0;
    col = '0;
    for (int c = 0; c < COLS; c++) begin
      if (!csync_q[c] && !hit) begin
        hit = 1'b1;
        col = COL_W'(c);
      end
    end
  end

  assign tick     = (div_q == DIV_W'(SCAN_DIV - 1));
  assign cand_low = ~csync_q[cand_col_q];
  assign row_next = (row_q == ROW_W'(ROWS - 1)) ? '0 : row_q + ROW_W'(1);

  // Next-state logic; everything except the synchroniser and divider moves on ticks only
  always_comb begin
    sync1_d    = colSense;
    csync_d    = sync1_q;
    div_d      = tick ? '0 : div_q + DIV_W'(1);
    state_d    = state_q;
    row_d      = row_q;
    cand_row_d = cand_row_q;
    cand_col_d = cand_col_q;
    cnt_d      = cnt_q;
    rel_cnt_d  = rel_cnt_q;
    press_evt  = 1'b0;
    rel_evt    = 1'b0;
    if (tick) begin
      case (state_q)
        ST_SCAN: begin
          if (hit) begin
            cand_row_d = row_q;
            cand_col_d = col;
            cnt_d      = CNT_W'(1);
            rel_cnt_d  = '0;
            if (ONE_SAMPLE) begin
              state_d   = ST_HELD;
              press_evt = 1'b1;
            end else begin
              state_d   = ST_CONFIRM;
            end
          end else begin
            row_d = row_next;
          end
        end
        ST_CONFIRM: begin
          if (cand_low) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q + CNT_W'(1) == CNT_W'(DEBOUNCE_SAMPLES)) begin
              state_d   = ST_HELD;
              press_evt = 1'b1;
              rel_cnt_d = '0;
            end
          end else begin
            state_d = ST_SCAN;
          end
        end
        ST_HELD: begin
          if (cand_low) begin
            rel_cnt_d = '0;
          end else if (rel_cnt_q + CNT_W'(1) == CNT_W'(DEBOUNCE_SAMPLES)) begin
            state_d   = ST_SCAN;
            row_d     = row_next;
            rel_cnt_d = '0;
`ifdef KEY_RELEASE_EVENT_EN
            rel_evt   = 1'b1;
`else
            rel_evt   = 1'b0;
`endif
          end else begin
            rel_cnt_d = rel_cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = ST_SCAN;
        end
      endcase
    end
  end

  assign evt      = press_evt | rel_evt;
  assign evt_code = CODE_W'(cand_row_d) * CODE_W'(COLS) + CODE_W'(cand_col_d);

  // Output logic: event emission, overflow and handshake
  always_comb begin
    key_valid_d = key_valid_q;
    key_code_d  = key_code_q;
    key_ovf_d   = 1'b0;
`ifdef KEY_RELEASE_EVENT_EN
    key_rel_d   = key_rel_q;
`endif
    if (evt) begin
      if (!key_valid_q || keyAck) begin
        key_valid_d = 1'b1;
        key_code_d  = evt_code;
`ifdef KEY_RELEASE_EVENT_EN
        key_rel_d   = rel_evt;
`endif
      end else begin
        key_ovf_d   = 1'b1;
      end
    end else if (keyAck && key_valid_q) begin
      key_valid_d = 1'b0;
    end
    rowDrive = ~(ROWS'(1) << row_q);
  end

  assign keyValid    = key_valid_q;
  assign keyCode     = key_code_q;
  assign keyOverflow = key_ovf_q;
`ifdef KEY_RELEASE_EVENT_EN
  assign keyRelease  = key_rel_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_matrix_key_scanner.sv
`default_nettype none
// ============================================================================
// Module  : tb_matrix_key_scanner
// Brief   : Directed and randomised checks of matrix_key_scanner against a
//           bench-side key matrix and event expectations.
// Revision: 1.0 - initial release
// ============================================================================
module tb_matrix_key_scanner;
  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int SCAN_DIV = 8;
  localparam int DEB = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] rowDrive;
  logic [3:0] colSense;
  logic       keyValid;
  logic [3:0] keyCode;
  logic       keyAck = 1'b0;
  logic       keyOverflow;
`ifdef KEY_RELEASE_EVENT_EN
  logic       keyRelease;
`endif

  logic [15:0] keys = '0;
  int n_chk = 0;
  int n_pass = 0;
  int t = 0;

  matrix_key_scanner #(
    .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SCAN_DIV), .DEBOUNCE_SAMPLES(DEB)
  ) dut (
    .clk(clk),
    .reset(reset),
    .rowDrive(rowDrive),
    .colSense(colSense),
    .keyValid(keyValid),
    .keyCode(keyCode),
    .keyAck(keyAck),
`ifdef KEY_RELEASE_EVENT_EN
    .keyRelease(keyRelease),
`endif
    .keyOverflow(keyOverflow)
  );

  always #5 clk = ~clk;

  // Physical matrix: a pressed key shorts its column to its row when the row is driven low
  always_comb begin
    colSense = '1;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (!rowDrive[r] && keys[r*COLS+c]) colSense[c] = 1'b0;
  end

  function automatic logic [3:0] rd(input int r);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << r);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // t counts clock edges since reset was released
  task automatic goto(input int n);
    step(n - t);
    t = n;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    keys = '0;
    keyAck = 1'b0;
    step(2);
    reset = 1'b0;
    t = 0;
  endtask

  task automatic wait_valid(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      if (keyValid) begin
        ok = 1'b1;
        break;
      end
      step(1);
    end
  endtask

  task automatic ack_pulse();
    keyAck = 1'b1;
    step(1);
    keyAck = 1'b0;
  endtask

  initial begin
    bit ok;
    int k;

    // Reset state and idle row rotation
    do_reset();
    chk("rst_valid", keyValid, 0);
    chk("rst_code", keyCode, 0);
    chk("rst_ovf", keyOverflow, 0);
    chk("rst_row", rowDrive, 4'b1110);
    for (int p = 0; p < 5; p++) begin
      goto(8 * p + 4);
      chk("idle_row", rowDrive, rd(p % 4));
    end
    chk("idle_valid", keyValid, 0);

    // Key 9 held: detected at edge 24, accepted on the third sample at edge 40
    do_reset();
    keys[9] = 1'b1;
    goto(32);
    chk("press_early", keyValid, 0);
    chk("press_row", rowDrive, 4'b1011);
    goto(39);
    chk("press_pre", keyValid, 0);
    goto(40);
    chk("press_valid", keyValid, 1);
    chk("press_code", keyCode, 9);
    goto(60);
    chk("held_row", rowDrive, 4'b1011);
    keys = '0;
    goto(81);
    chk("rel_row", rowDrive, 4'b0111);
    ack_pulse();
    chk("ack_clear", keyValid, 0);

    // Bounce: released after one sample, scan resumes from row 2
    do_reset();
    keys[9] = 1'b1;
    goto(24);
    keys = '0;
    goto(33);
    chk("bounce_row2", rowDrive, 4'b1011);
    goto(41);
    chk("bounce_row3", rowDrive, 4'b0111);
    chk("bounce_valid", keyValid, 0);

    // Overflow: key 3 accepted at edge 96 while code 9 still pending
    do_reset();
    keys[9] = 1'b1;
    goto(41);
    keys = 16'h0008;
    goto(95);
    chk("ovf_pre", keyOverflow, 0);
    goto(96);
    chk("ovf_pulse", keyOverflow, 1);
    chk("ovf_code", keyCode, 9);
    chk("ovf_valid", keyValid, 1);
    goto(97);
    chk("ovf_single", keyOverflow, 0);

    // Same sequence with ack on the emit cycle
    do_reset();
    keys[9] = 1'b1;
    goto(41);
    keys = 16'h0008;
    goto(95);
    keyAck = 1'b1;
    goto(96);
    keyAck = 1'b0;
    chk("ackemit_code", keyCode, 3);
    chk("ackemit_valid", keyValid, 1);
    chk("ackemit_ovf", keyOverflow, 0);
    goto(97);
    chk("ackemit_hold", keyValid, 1);

    // Two keys in row 1: lowest column reported, the other never
    do_reset();
    keys[4] = 1'b1;
    keys[6] = 1'b1;
    goto(33);
    chk("multi_valid", keyValid, 1);
    chk("multi_code", keyCode, 4);
    ack_pulse();
    t++;
    chk("multi_ack", keyValid, 0);
    goto(150);
    chk("multi_quiet", keyValid, 0);
    chk("multi_row", rowDrive, 4'b1101);

    // Reset during CONFIRM and with an event pending
    do_reset();
    keys[9] = 1'b1;
    goto(28);
    reset = 1'b1;
    step(1);
    chk("rstc_valid", keyValid, 0);
    chk("rstc_row", rowDrive, 4'b1110);
    do_reset();
    keys[9] = 1'b1;
    goto(45);
    chk("rstp_pend", keyValid, 1);
    reset = 1'b1;
    step(1);
    chk("rstp_valid", keyValid, 0);
    chk("rstp_row", rowDrive, 4'b1110);

`ifdef KEY_RELEASE_EVENT_EN
    do_reset();
    keys[15] = 1'b1;
    wait_valid(200, ok);
    chk("k15_press_seen", ok, 1);
    chk("k15_press_code", keyCode, 15);
    chk("k15_press_rel", keyRelease, 0);
    ack_pulse();
    chk("k15_press_ack", keyValid, 0);
    step(20);
    keys = '0;
    wait_valid(200, ok);
    chk("k15_rel_seen", ok, 1);
    chk("k15_rel_code", keyCode, 15);
    chk("k15_rel_rel", keyRelease, 1);
    ack_pulse();
`endif

    // Random single-key presses: each long press yields exactly its own code
    do_reset();
    for (int i = 0; i < 12; i++) begin
      k = $urandom_range(0, 15);
      step($urandom_range(0, 9));
      keys = '0;
      keys[k] = 1'b1;
      wait_valid(200, ok);
      chk("rnd_seen", ok, 1);
      chk("rnd_code", keyCode, k);
      chk("rnd_row", rowDrive, rd(k / COLS));
`ifdef KEY_RELEASE_EVENT_EN
      chk("rnd_press_rel", keyRelease, 0);
`endif
      step($urandom_range(0, 4));
      ack_pulse();
      chk("rnd_ack", keyValid, 0);
      step($urandom_range(0, 30));
      keys = '0;
`ifdef KEY_RELEASE_EVENT_EN
      wait_valid(200, ok);
      chk("rnd_rel_seen", ok, 1);
      chk("rnd_rel_code", keyCode, k);
      chk("rnd_rel_rel", keyRelease, 1);
      ack_pulse();
`else
      step(40 + $urandom_range(0, 10));
      chk("rnd_rel_quiet", keyValid, 0);
`endif
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
